// File: rtl/alu_pkg.sv
// alu_pkg: operation codes, exception bit positions and multiplier FSM state
// shared by the ALU pipeline and its iterative multiplier.
package alu_pkg;

  localparam logic [5:0] FN_ADD = 6'd1;
  localparam logic [5:0] FN_SUB = 6'd2;
  localparam logic [5:0] FN_SRA = 6'd3;
  localparam logic [5:0] FN_AND = 6'd4;
  localparam logic [5:0] FN_OR  = 6'd5;
  localparam logic [5:0] FN_SLL = 6'd6;
  localparam logic [5:0] FN_SRL = 6'd7;
  localparam logic [5:0] FN_XOR = 6'd8;
  localparam logic [5:0] FN_MUL = 6'd9;

  localparam int unsigned EXC_OVF   = 0;
  localparam int unsigned EXC_MULHI = 1;
  localparam int unsigned EXC_RSVD  = 2;
  localparam int unsigned EXC_UNK   = 3;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_MUL  = 1'b1
  } mul_state_e;

  function automatic logic [3:0] exc_bit(input int unsigned idx);
    exc_bit = 4'b0001 << idx;
  endfunction

endpackage

// File: rtl/alu_pipe_if.sv
// alu_pipe_if: request/result handshake bundle between an ALU client (master)
// and the ALU pipeline (slave).
interface alu_pipe_if #(
  parameter int WIDTH = 32,
  parameter int TAG_W = 4
);
  localparam int SH_W = $clog2(WIDTH);

  logic             in_valid;
  logic             in_ready;
  logic [5:0]       func_sel;
  logic [WIDTH-1:0] data_in0;
  logic [WIDTH-1:0] data_in1;
  logic [SH_W-1:0]  shamt;
  logic [TAG_W-1:0] tag_in;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] data_out;
  logic             carry_out;
  logic [3:0]       exc_out;
  logic [TAG_W-1:0] tag_out;
  logic             busy;

  modport master (
    output in_valid, func_sel, data_in0, data_in1, shamt, tag_in, out_ready,
    input  in_ready, out_valid, data_out, carry_out, exc_out, tag_out, busy
  );

  modport slave (
    input  in_valid, func_sel, data_in0, data_in1, shamt, tag_in, out_ready,
    output in_ready, out_valid, data_out, carry_out, exc_out, tag_out, busy
  );

endinterface

// File: rtl/alu_mul_seq.sv
// alu_mul_seq: unsigned shift-add multiplier, one partial product per cycle,
// WIDTH cycles from start to result load; holds its result until the consumer is free.
module alu_mul_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int TAG_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic [TAG_W-1:0] tag_i,
  input  logic             out_free_i,
  output logic             busy_o,
  output logic             load_o,
  output logic [WIDTH-1:0] prod_lo_o,
  output logic             hi_nz_o,
  output logic [TAG_W-1:0] tag_o
);
  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  mul_state_e state_q, state_d;

  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [2*WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0]   mplier_q, mplier_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [TAG_W-1:0]   tag_q, tag_d;
  logic [2*WIDTH-1:0] addend;
  logic [2*WIDTH-1:0] step_acc;
  logic               last_step;

  genvar gi;
  generate
    for (gi = 0; gi < 2 * WIDTH; gi++) begin : g_addend
      assign addend[gi] = mcand_q[gi] & mplier_q[0];
    end
  endgenerate

  // The final partial product is folded in combinationally so the result can
  // be loaded on the WIDTH-th edge after start.
  assign step_acc  = acc_q + addend;
  assign last_step = (cnt_q == LAST);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (start_i) state_d = ST_MUL;
      ST_MUL:  if (last_step && out_free_i) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    busy_o = 1'b0;
    load_o = 1'b0;
    case (state_q)
      ST_MUL: begin
        busy_o = 1'b1;
        load_o = last_step && out_free_i;
      end
      default: ;
    endcase
  end

  always_comb begin
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    cnt_d    = cnt_q;
    tag_d    = tag_q;
    if (state_q == ST_IDLE && start_i) begin
      acc_d    = '0;
      mcand_d  = {{WIDTH{1'b0}}, a_i};
      mplier_d = b_i;
      cnt_d    = '0;
      tag_d    = tag_i;
    end else if (state_q == ST_MUL && !last_step) begin
      acc_d    = step_acc;
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
      cnt_d    = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
      tag_q    <= '0;
    end else begin
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      cnt_q    <= cnt_d;
      tag_q    <= tag_d;
    end
  end

  assign prod_lo_o = step_acc[WIDTH-1:0];
  assign hi_nz_o   = |step_acc[2*WIDTH-1:WIDTH];
  assign tag_o     = tag_q;

endmodule

// File: rtl/alu_pipe.sv
// alu_pipe: single-entry registered ALU with valid/ready flow control.
// Define ALU_MUL_EN to include the iterative multiplier for code 9.
module alu_pipe
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int TAG_W = 4
) (
  input  logic      clk,
  input  logic      reset,
  alu_pipe_if.slave bus
);
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             carry_q, carry_d;
  logic [3:0]       exc_q, exc_d;
  logic [TAG_W-1:0] tag_q, tag_d;

  logic             out_free;
  logic             busy;
  logic             fire;
  logic             is_mul;
  logic             mul_load;
  logic             mul_hi_nz;
  logic [WIDTH-1:0] mul_lo;
  logic [TAG_W-1:0] mul_tag;

  logic [WIDTH-1:0] a, b;
  logic [WIDTH:0]   sum_ext, diff_ext;
  logic [WIDTH-1:0] alu_res;
  logic             alu_carry;
  logic [3:0]       alu_exc;

  assign a        = bus.data_in0;
  assign b        = bus.data_in1;
  assign out_free = !out_valid_q || bus.out_ready;
  assign fire     = bus.in_valid && bus.in_ready;

  assign bus.in_ready = !busy && out_free;
  assign bus.busy     = busy;

  // Bit WIDTH of the extended difference is the unsigned borrow.
  assign sum_ext  = {1'b0, a} + {1'b0, b};
  assign diff_ext = {1'b0, a} - {1'b0, b};

  always_comb begin
    alu_res   = '0;
    alu_carry = 1'b0;
    alu_exc   = '0;
    case (bus.func_sel)
      FN_ADD: begin
        alu_res   = sum_ext[WIDTH-1:0];
        alu_carry = sum_ext[WIDTH];
        alu_exc[EXC_OVF] = (a[WIDTH-1] == b[WIDTH-1]) && (sum_ext[WIDTH-1] != a[WIDTH-1]);
      end
      FN_SUB: begin
        alu_res   = diff_ext[WIDTH-1:0];
        alu_carry = diff_ext[WIDTH];
        alu_exc[EXC_OVF] = (a[WIDTH-1] != b[WIDTH-1]) && (diff_ext[WIDTH-1] != a[WIDTH-1]);
      end
      FN_SRA:  alu_res = $unsigned($signed(a) >>> bus.shamt);
      FN_AND:  alu_res = a & b;
      FN_OR:   alu_res = a | b;
      FN_SLL:  alu_res = a << bus.shamt;
      FN_SRL:  alu_res = a >> bus.shamt;
      FN_XOR:  alu_res = a ^ b;
      default: alu_exc = exc_bit(EXC_UNK);
    endcase
  end

`ifdef ALU_MUL_EN
  logic mul_start;

  assign is_mul    = (bus.func_sel == FN_MUL);
  assign mul_start = fire && is_mul;

  alu_mul_seq #(
    .WIDTH(WIDTH),
    .TAG_W(TAG_W)
  ) u_mul (
    .clk       (clk),
    .reset     (reset),
    .start_i   (mul_start),
    .a_i       (a),
    .b_i       (b),
    .tag_i     (bus.tag_in),
    .out_free_i(out_free),
    .busy_o    (busy),
    .load_o    (mul_load),
    .prod_lo_o (mul_lo),
    .hi_nz_o   (mul_hi_nz),
    .tag_o     (mul_tag)
  );
`else
  // Code 9 falls through to the unknown-operation path.
  assign is_mul    = 1'b0;
  assign busy      = 1'b0;
  assign mul_load  = 1'b0;
  assign mul_lo    = '0;
  assign mul_hi_nz = 1'b0;
  assign mul_tag   = '0;
`endif

  // A new load and a consume can share an edge; the load wins.
  always_comb begin
    out_valid_d = out_valid_q;
    data_d      = data_q;
    carry_d     = carry_q;
    exc_d       = exc_q;
    tag_d       = tag_q;
    if (out_valid_q && bus.out_ready) begin
      out_valid_d = 1'b0;
    end
    if (fire && !is_mul) begin
      out_valid_d = 1'b1;
      data_d      = alu_res;
      carry_d     = alu_carry;
      exc_d       = alu_exc;
      tag_d       = bus.tag_in;
    end
    if (mul_load) begin
      out_valid_d = 1'b1;
      data_d      = mul_lo;
      carry_d     = 1'b0;
      exc_d       = mul_hi_nz ? exc_bit(EXC_MULHI) : 4'b0000;
      tag_d       = mul_tag;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid_q <= 1'b0;
      data_q      <= '0;
      carry_q     <= 1'b0;
      exc_q       <= '0;
      tag_q       <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      data_q      <= data_d;
      carry_q     <= carry_d;
      exc_q       <= exc_d;
      tag_q       <= tag_d;
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.data_out  = data_q;
  assign bus.carry_out = carry_q;
  assign bus.exc_out   = exc_q;
  assign bus.tag_out   = tag_q;

endmodule

// File: tb/tb_alu_pipe.sv
// tb_alu_pipe: directed vector table plus hand-written stall, multiply and
// reset sequences for alu_pipe at WIDTH=32.
module tb_alu_pipe;
  import alu_pkg::*;

  localparam int WIDTH = 32;
  localparam int TAG_W = 4;
  localparam int NVEC  = 13;

  logic clk = 1'b0;
  logic reset;
  int   checks   = 0;
  int   failures = 0;

  alu_pipe_if #(.WIDTH(WIDTH), .TAG_W(TAG_W)) bus ();

  alu_pipe #(.WIDTH(WIDTH), .TAG_W(TAG_W)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [5:0]  func;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  sh;
    logic [31:0] exp_data;
    logic        exp_carry;
    logic [3:0]  exp_exc;
  } vec_t;

  vec_t vecs [NVEC];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] sh, input logic [3:0] tag);
    bus.in_valid = 1'b1;
    bus.func_sel = f;
    bus.data_in0 = a;
    bus.data_in1 = b;
    bus.shamt    = sh;
    bus.tag_in   = tag;
  endtask

  // Waits (bounded) for out_valid after a mul accept; returns latency and busy cycles.
  task automatic wait_result(output int lat, output int busy_cnt);
    lat = 0;
    busy_cnt = 0;
    while (!bus.out_valid && lat < 40) begin
      if (bus.busy && !bus.in_ready) busy_cnt++;
      tick();
      lat++;
    end
  endtask

  initial begin
    int lat;
    int busy_cnt;
    int seen;

    vecs[0]  = '{FN_ADD, 32'h7FFF_FFFF, 32'h0000_0001, 5'd0, 32'h8000_0000, 1'b0, 4'b0001};
    vecs[1]  = '{FN_ADD, 32'hFFFF_FFFF, 32'h0000_0001, 5'd0, 32'h0000_0000, 1'b1, 4'b0000};
    vecs[2]  = '{FN_SUB, 32'h0000_0000, 32'h0000_0001, 5'd0, 32'hFFFF_FFFF, 1'b1, 4'b0000};
    vecs[3]  = '{FN_SUB, 32'h8000_0000, 32'h0000_0001, 5'd0, 32'h7FFF_FFFF, 1'b0, 4'b0001};
    vecs[4]  = '{FN_SRA, 32'h8000_0000, 32'h0000_0000, 5'd4, 32'hF800_0000, 1'b0, 4'b0000};
    vecs[5]  = '{FN_SRL, 32'h8000_0000, 32'h0000_0000, 5'd4, 32'h0800_0000, 1'b0, 4'b0000};
    vecs[6]  = '{FN_SLL, 32'h0000_0001, 32'h0000_0000, 5'd31, 32'h8000_0000, 1'b0, 4'b0000};
    vecs[7]  = '{FN_AND, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 5'd0, 32'h00F0_00F0, 1'b0, 4'b0000};
    vecs[8]  = '{FN_OR,  32'hF0F0_F0F0, 32'h0FF0_0FF0, 5'd0, 32'hFFF0_FFF0, 1'b0, 4'b0000};
    vecs[9]  = '{FN_XOR, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 5'd0, 32'hFF00_FF00, 1'b0, 4'b0000};
    vecs[10] = '{FN_SRA, 32'h8000_0001, 32'h0000_0000, 5'd0, 32'h8000_0001, 1'b0, 4'b0000};
    vecs[11] = '{6'd12,  32'h1234_5678, 32'h0000_0001, 5'd0, 32'h0000_0000, 1'b0, 4'b1000};
    vecs[12] = '{6'd0,   32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd3, 32'h0000_0000, 1'b0, 4'b1000};

    bus.in_valid  = 1'b0;
    bus.func_sel  = '0;
    bus.data_in0  = '0;
    bus.data_in1  = '0;
    bus.shamt     = '0;
    bus.tag_in    = '0;
    bus.out_ready = 1'b1;
    reset         = 1'b1;

    tick();
    tick();
    check("rst_out_valid", 64'(bus.out_valid), 64'd0);
    check("rst_busy",      64'(bus.busy),      64'd0);
    check("rst_data",      64'(bus.data_out),  64'd0);
    check("rst_carry",     64'(bus.carry_out), 64'd0);
    check("rst_exc",       64'(bus.exc_out),   64'd0);
    check("rst_tag",       64'(bus.tag_out),   64'd0);
    reset = 1'b0;
    #1;
    check("rst_in_ready", 64'(bus.in_ready), 64'd1);

    // Back-to-back vectors: each result appears one edge after its accept.
    for (int i = 0; i < NVEC; i++) begin
      drive(vecs[i].func, vecs[i].a, vecs[i].b, vecs[i].sh, TAG_W'(i));
      tick();
      $display("vec %0d func=%0d a=%h b=%h sh=%0d -> data=%h carry=%0b exc=%b tag=%0d",
               i, vecs[i].func, vecs[i].a, vecs[i].b, vecs[i].sh,
               bus.data_out, bus.carry_out, bus.exc_out, bus.tag_out);
      check($sformatf("v%0d_valid", i), 64'(bus.out_valid), 64'd1);
      check($sformatf("v%0d_data", i),  64'(bus.data_out),  64'(vecs[i].exp_data));
      check($sformatf("v%0d_carry", i), 64'(bus.carry_out), 64'(vecs[i].exp_carry));
      check($sformatf("v%0d_exc", i),   64'(bus.exc_out),   64'(vecs[i].exp_exc));
      check($sformatf("v%0d_tag", i),   64'(bus.tag_out),   64'(i % 16));
    end
    bus.in_valid = 1'b0;
    tick();
    check("drain_valid", 64'(bus.out_valid), 64'd0);

    // Output stall: result held, no accept, then one consume per cycle.
    bus.out_ready = 1'b0;
    drive(FN_ADD, 32'd5, 32'd3, 5'd0, 4'd1);
    tick();
    drive(FN_SUB, 32'd10, 32'd4, 5'd0, 4'd2);
    for (int k = 0; k < 3; k++) begin
      #1;
      $display("stall %0d in_ready=%0b data=%h tag=%0d", k, bus.in_ready, bus.data_out, bus.tag_out);
      check($sformatf("stall%0d_in_ready", k), 64'(bus.in_ready),  64'd0);
      check($sformatf("stall%0d_valid", k),    64'(bus.out_valid), 64'd1);
      check($sformatf("stall%0d_data", k),     64'(bus.data_out),  64'd8);
      check($sformatf("stall%0d_tag", k),      64'(bus.tag_out),   64'd1);
      tick();
    end
    bus.out_ready = 1'b1;
    #1;
    check("release_in_ready", 64'(bus.in_ready), 64'd1);
    tick();
    bus.in_valid = 1'b0;
    $display("release data=%h tag=%0d", bus.data_out, bus.tag_out);
    check("release_valid", 64'(bus.out_valid), 64'd1);
    check("release_data",  64'(bus.data_out),  64'd6);
    check("release_tag",   64'(bus.tag_out),   64'd2);
    tick();
    check("release_drain", 64'(bus.out_valid), 64'd0);

`ifdef ALU_MUL_EN
    // Multiply with a non-zero high half.
    drive(FN_MUL, 32'h0001_0000, 32'h0001_0000, 5'd0, 4'd5);
    tick();
    bus.in_valid = 1'b0;
    wait_result(lat, busy_cnt);
    $display("mul0 lat=%0d busy=%0d data=%h exc=%b", lat, busy_cnt, bus.data_out, bus.exc_out);
    check("mul0_latency", 64'(lat),           64'd32);
    check("mul0_busy",    64'(busy_cnt),      64'd32);
    check("mul0_data",    64'(bus.data_out),  64'd0);
    check("mul0_exc",     64'(bus.exc_out),   64'b0010);
    check("mul0_carry",   64'(bus.carry_out), 64'd0);
    check("mul0_tag",     64'(bus.tag_out),   64'd5);
    check("mul0_idle",    64'(bus.busy),      64'd0);
    tick();

    // Multiply whose result is left unconsumed for two cycles.
    drive(FN_MUL, 32'd7, 32'd6, 5'd0, 4'd6);
    tick();
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    wait_result(lat, busy_cnt);
    $display("mul1 lat=%0d data=%h exc=%b", lat, bus.data_out, bus.exc_out);
    check("mul1_latency", 64'(lat),          64'd32);
    check("mul1_data",    64'(bus.data_out), 64'd42);
    check("mul1_exc",     64'(bus.exc_out),  64'd0);
    tick();
    tick();
    check("mul1_hold_data",  64'(bus.data_out), 64'd42);
    check("mul1_hold_valid", 64'(bus.out_valid), 64'd1);
    check("mul1_hold_ready", 64'(bus.in_ready), 64'd0);
    bus.out_ready = 1'b1;
    tick();
    check("mul1_consumed", 64'(bus.out_valid), 64'd0);

    // Reset part-way through a multiply aborts it.
    drive(FN_MUL, 32'd3, 32'd3, 5'd0, 4'd7);
    tick();
    bus.in_valid = 1'b0;
    repeat (9) tick();
    reset = 1'b1;
    tick();
    check("mulrst_busy",  64'(bus.busy),      64'd0);
    check("mulrst_valid", 64'(bus.out_valid), 64'd0);
    reset = 1'b0;
    #1;
    check("mulrst_in_ready", 64'(bus.in_ready), 64'd1);
    seen = 0;
    for (int k = 0; k < 40; k++) begin
      tick();
      if (bus.out_valid) seen++;
    end
    $display("mulrst stray results=%0d", seen);
    check("mulrst_no_result", 64'(seen), 64'd0);
`else
    // Without the multiplier code 9 behaves as unknown.
    drive(FN_MUL, 32'h0001_0000, 32'h0001_0000, 5'd0, 4'd5);
    tick();
    bus.in_valid = 1'b0;
    $display("mul-off data=%h exc=%b busy=%0b", bus.data_out, bus.exc_out, bus.busy);
    check("muloff_valid", 64'(bus.out_valid), 64'd1);
    check("muloff_data",  64'(bus.data_out),  64'd0);
    check("muloff_exc",   64'(bus.exc_out),   64'b1000);
    check("muloff_busy",  64'(bus.busy),      64'd0);
    tick();

    // Reset discards a pending result.
    bus.out_ready = 1'b0;
    drive(FN_ADD, 32'd1, 32'd2, 5'd0, 4'd7);
    tick();
    bus.in_valid = 1'b0;
    check("pend_valid", 64'(bus.out_valid), 64'd1);
    reset = 1'b1;
    tick();
    check("pendrst_valid", 64'(bus.out_valid), 64'd0);
    check("pendrst_data",  64'(bus.data_out),  64'd0);
    reset = 1'b0;
    bus.out_ready = 1'b1;
    #1;
    check("pendrst_in_ready", 64'(bus.in_ready), 64'd1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/alu_pipe.md
ALU_PIPE -- requirements
Module: alu_pipe

Interface
REQ-001 SHALL have parameter WIDTH, default 32: operand and result width in bits, minimum 8.
REQ-002 SHALL have parameter TAG_W, default 4: width of the opaque tag carried with each operation.
REQ-003 SHALL have port clk  input  1: single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  input  1: synchronous, active-high reset.
REQ-005 SHALL have port in_valid  input  1: request present.
REQ-006 SHALL have port in_ready  output  1: request accepted at the edge when in_valid && in_ready.
REQ-007 SHALL have port func_sel  input  6: operation code.
REQ-008 SHALL have ports data_in0 and data_in1  input  WIDTH: operands.
REQ-009 SHALL have port shamt  input  $clog2(WIDTH): shift amount.
REQ-010 SHALL have port tag_in  input  TAG_W: returned unchanged on tag_out.
REQ-011 SHALL have port out_valid  output  1: result held.
REQ-012 SHALL have port out_ready  input  1: result consumed at the edge when out_valid && out_ready.
REQ-013 SHALL have port data_out  output  WIDTH: result.
REQ-014 SHALL have port carry_out  output  1: carry/borrow.
REQ-015 SHALL have port exc_out  output  4: exception flags.
REQ-016 SHALL have port tag_out  output  TAG_W: tag of the held result.
REQ-017 SHALL have port busy  output  1: high while a multiply iterates.

Function
REQ-018 SHALL decode func_sel as: 1 add, 2 sub, 3 arithmetic shift right (sign fill), 4 and, 5 or, 6 shift left, 7 logical shift right, 8 xor, 9 mul; all other codes are unknown.
REQ-019 SHALL drive in_ready = !busy && (!out_valid || out_ready).
REQ-020 SHALL register a single-cycle operation accepted at edge N so that out_valid is high after edge N, giving latency 1; throughput is 1 per cycle while out_ready stays high.
REQ-021 SHALL hold data_out, carry_out, exc_out and tag_out stable while out_valid && !out_ready.
REQ-022 SHALL, for add, output the WIDTH-bit sum; carry_out = unsigned carry; exc_out[0] = signed overflow.
REQ-023 SHALL, for sub, output data_in0 - data_in1; carry_out = borrow (data_in0 < data_in1 unsigned); exc_out[0] = signed overflow.
REQ-024 SHALL, for logic and shift operations, output carry_out = 0 and exc_out = 0; shamt 0 returns data_in0 unchanged.
REQ-025 SHALL, for an unknown code, output data_out = 0, carry_out = 0, exc_out = 4'b1000, with latency 1.
REQ-026 SHALL execute mul as an iterative unsigned shift-add through FSM states IDLE -> MUL (WIDTH cycles) -> IDLE; accepted at edge N, out_valid rises after edge N+WIDTH.
REQ-027 SHALL output the low WIDTH bits of the mul product, with exc_out[1] = (high half != 0) and carry_out = 0.
REQ-028 SHALL wait in MUL until the output register is free (out_valid low or being consumed) before loading the result; busy stays high until the load.
REQ-029 SHALL keep exc_out[2] at 0 (reserved).

Reset
REQ-030 SHALL, while reset is high, clear out_valid, busy, data_out, carry_out, exc_out and tag_out to 0 and return the FSM to IDLE.
REQ-031 SHALL, on reset during MUL, abort the operation and produce no result; in_ready is 1 in the first cycle after reset deasserts.

Configuration
REQ-032 SHALL, with ALU_MUL_EN defined, implement mul as specified in REQ-026 to REQ-028.
REQ-033 SHALL, without ALU_MUL_EN, treat code 9 as unknown (REQ-025); busy is then tied to 0 and no multiplier logic is present.

Structure
REQ-034 SHALL take the func_sel code constants, the exc_out bit indices and the FSM state type from the shared package alu_pkg.
REQ-035 SHALL place the iterative multiplier, with its counter and partial-product registers, in the sub-module alu_mul_seq.

Verification (WIDTH=32)
REQ-036 SHALL check: add 0x7FFFFFFF + 0x1 -> data_out 0x80000000, carry_out 0, exc_out 4'b0001, out_valid one cycle after accept.
REQ-037 SHALL check: sub 0x0 - 0x1 -> data_out 0xFFFFFFFF, carry_out 1, exc_out 0; shra 0x80000000 with shamt 4 -> 0xF8000000; shrl of the same -> 0x08000000.
REQ-038 SHALL check: out_ready held low for 3 cycles with in_valid high -> in_ready 0 and outputs stable; on release, one result is consumed per cycle.
REQ-039 SHALL check: mul 0x00010000 * 0x00010000 -> data_out 0, exc_out 4'b0010, out_valid 32 cycles after accept, busy high throughout; without ALU_MUL_EN -> exc_out 4'b1000 after 1 cycle.
REQ-040 SHALL check: reset asserted 10 cycles into a mul -> out_valid never rises for it, and in_ready is 1 after reset deasserts; func_sel 12 -> data_out 0, exc_out 4'b1000.
